// File: rtl/float_div.sv
// -----------------------------------------------------------------------------
// float_div -- iterative IEEE-754 single-precision divider.
//
// Restoring division of the two 24-bit mantissas (hidden 1 always inserted),
// one quotient bit per cycle for 26 cycles, then a normalisation cycle that
// registers the result and status flags. Inf/NaN/denormals are not treated
// specially.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   in_valid     operand pair present
//   in_ready     high only while idle; pair accepted on in_valid & in_ready
//   input_a      dividend {sign, exp[7:0], mant[22:0]}
//   input_b      divisor, same format
//   out_valid    one-cycle pulse when quotient/flags are updated
//   quotient     registered result, held until the next result or reset
//   overflow     result exponent >= 255
//   underflow    result exponent <= 0
//   div_by_zero  divisor was exactly 32'h0
//
// Configuration macro:
//   FLOAT_DIV_ROUND_EN  defined  -> round-half-up on the guard bit
//                       undefined -> truncation (default)
// -----------------------------------------------------------------------------
module float_div (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] input_a,
    input  logic [31:0] input_b,
    output logic        out_valid,
    output logic [31:0] quotient,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIVIDE = 2'd1,
        NORM   = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic [4:0]   cnt_q, cnt_d;
    logic [25:0]  rem_q, rem_d;
    logic [25:0]  q_q, q_d;
    logic [23:0]  mb_q, mb_d;
    logic [7:0]   exp_a_q, exp_a_d;
    logic [7:0]   exp_b_q, exp_b_d;
    logic         sign_q, sign_d;
    logic         a_zero_q, a_zero_d;
    logic         b_zero_q, b_zero_d;
    logic         out_valid_q, out_valid_d;
    logic [31:0]  quotient_q, quotient_d;
    logic         overflow_q, overflow_d;
    logic         underflow_q, underflow_d;
    logic         div_by_zero_q, div_by_zero_d;

    // normalisation / rounding intermediates
    logic [22:0]        mant_s;
    logic               guard_s;
    logic signed [9:0]  exp_s;
    logic [22:0]        mant_fin_s;
    logic signed [9:0]  exp_fin_s;
`ifdef FLOAT_DIV_ROUND_EN
    logic [23:0]        mant_rnd_s;
`else
    logic               unused_guard_s;
`endif
    logic [25:0]        diff_s;

    // Normalise the raw quotient and apply rounding or truncation.
    always_comb begin
        mant_s  = 23'd0;
        guard_s = 1'b0;
        exp_s   = $signed({2'b00, exp_a_q}) - $signed({2'b00, exp_b_q}) + 10'sd127;
        if (q_q[25]) begin
            mant_s  = q_q[24:2];
            guard_s = q_q[1];
        end else begin
            mant_s  = q_q[23:1];
            guard_s = q_q[0];
            exp_s   = exp_s - 10'sd1;
        end
`ifdef FLOAT_DIV_ROUND_EN
        mant_rnd_s = {1'b0, mant_s} + {23'd0, guard_s};
        // carry out of the 23-bit fraction bumps the exponent
        if (mant_rnd_s[23]) begin
            mant_fin_s = 23'd0;
            exp_fin_s  = exp_s + 10'sd1;
        end else begin
            mant_fin_s = mant_rnd_s[22:0];
            exp_fin_s  = exp_s;
        end
`else
        // truncation: the guard bit is deliberately dropped
        unused_guard_s = guard_s;
        mant_fin_s     = mant_s;
        exp_fin_s      = exp_s;
`endif
    end

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rem_d         = rem_q;
        q_d           = q_q;
        mb_d          = mb_q;
        exp_a_d       = exp_a_q;
        exp_b_d       = exp_b_q;
        sign_d        = sign_q;
        a_zero_d      = a_zero_q;
        b_zero_d      = b_zero_q;
        out_valid_d   = 1'b0;
        quotient_d    = quotient_q;
        overflow_d    = overflow_q;
        underflow_d   = underflow_q;
        div_by_zero_d = div_by_zero_q;
        diff_s        = rem_q - {2'b00, mb_q};
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = DIVIDE;
                    cnt_d    = 5'd0;
                    rem_d    = {3'b001, input_a[22:0]};
                    q_d      = 26'd0;
                    mb_d     = {1'b1, input_b[22:0]};
                    exp_a_d  = input_a[30:23];
                    exp_b_d  = input_b[30:23];
                    sign_d   = input_a[31] ^ input_b[31];
                    a_zero_d = (input_a == 32'd0);
                    b_zero_d = (input_b == 32'd0);
                end else begin
                    state_d = IDLE;
                end
            end
            DIVIDE: begin
                // restoring step: subtract if it fits, shift remainder left
                if (rem_q >= {2'b00, mb_q}) begin
                    q_d   = {q_q[24:0], 1'b1};
                    rem_d = {diff_s[24:0], 1'b0};
                end else begin
                    q_d   = {q_q[24:0], 1'b0};
                    rem_d = {rem_q[24:0], 1'b0};
                end
                if (cnt_q == 5'd25) begin
                    state_d = NORM;
                    cnt_d   = 5'd0;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            NORM: begin
                state_d       = DONE;
                out_valid_d   = 1'b1;
                overflow_d    = 1'b0;
                underflow_d   = 1'b0;
                div_by_zero_d = 1'b0;
                if (b_zero_q) begin
                    div_by_zero_d = 1'b1;
                    quotient_d    = {sign_q, 8'hFF, 23'd0};
                end else if (a_zero_q) begin
                    quotient_d = 32'd0;
                end else if (exp_fin_s >= 10'sd255) begin
                    overflow_d = 1'b1;
                    quotient_d = {sign_q, 8'hFF, 23'd0};
                end else if (exp_fin_s <= 10'sd0) begin
                    underflow_d = 1'b1;
                    quotient_d  = 32'd0;
                end else begin
                    quotient_d = {sign_q, exp_fin_s[7:0], mant_fin_s};
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= 5'd0;
            rem_q         <= 26'd0;
            q_q           <= 26'd0;
            mb_q          <= 24'd0;
            exp_a_q       <= 8'd0;
            exp_b_q       <= 8'd0;
            sign_q        <= 1'b0;
            a_zero_q      <= 1'b0;
            b_zero_q      <= 1'b0;
            out_valid_q   <= 1'b0;
            quotient_q    <= 32'd0;
            overflow_q    <= 1'b0;
            underflow_q   <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rem_q         <= rem_d;
            q_q           <= q_d;
            mb_q          <= mb_d;
            exp_a_q       <= exp_a_d;
            exp_b_q       <= exp_b_d;
            sign_q        <= sign_d;
            a_zero_q      <= a_zero_d;
            b_zero_q      <= b_zero_d;
            out_valid_q   <= out_valid_d;
            quotient_q    <= quotient_d;
            overflow_q    <= overflow_d;
            underflow_q   <= underflow_d;
            div_by_zero_q <= div_by_zero_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;
    assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_float_div.sv
// -----------------------------------------------------------------------------
// tb_float_div -- self-checking bench for float_div.
// Directed vectors, randomized vectors against a behavioural model built on
// integer division, mid-operation reset, and back-to-back held in_valid.
// -----------------------------------------------------------------------------
module tb_float_div;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] input_a = 32'd0;
    logic [31:0] input_b = 32'd0;
    logic        out_valid;
    logic [31:0] quotient;
    logic        overflow;
    logic        underflow;
    logic        div_by_zero;

    int checks = 0;
    int errors = 0;

    float_div dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .input_a     (input_a),
        .input_b     (input_b),
        .out_valid   (out_valid),
        .quotient    (quotient),
        .overflow    (overflow),
        .underflow   (underflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: returns {div_by_zero, overflow, underflow, quotient}.
    function automatic logic [34:0] ref_div(input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, q, mant;
        int e;
        logic s, g;
        ma = 64'h800000 | longint'(a[22:0]);
        mb = 64'h800000 | longint'(b[22:0]);
        q  = (ma << 25) / mb;
        s  = a[31] ^ b[31];
        e  = int'(a[30:23]) - int'(b[30:23]) + 127;
        if (q >= 64'd33554432) begin
            mant = (q >> 2) & 64'h7FFFFF;
            g    = q[1];
        end else begin
            mant = (q >> 1) & 64'h7FFFFF;
            g    = q[0];
            e    = e - 1;
        end
`ifdef FLOAT_DIV_ROUND_EN
        mant = mant + longint'(g);
        if (mant == 64'h800000) begin
            mant = 64'd0;
            e    = e + 1;
        end
`else
        g = 1'b0;
`endif
        if (b == 32'd0)  return {3'b100, s, 8'hFF, 23'd0};
        if (a == 32'd0)  return {3'b000, 32'd0};
        if (e >= 255)    return {3'b010, s, 8'hFF, 23'd0};
        if (e <= 0)      return {3'b001, 32'd0};
        return {3'b000, s, 8'(e), mant[22:0]};
    endfunction

    // Issue one pair, check latency, result, flags and the return to idle.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [34:0] exp);
        int lat;
        @(negedge clk);
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1;
        input_a  = a;
        input_b  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, 27);
        check("quotient", quotient, exp[31:0]);
        check("flags_dz_ov_un", {29'd0, div_by_zero, overflow, underflow}, {29'd0, exp[34:32]});
        check("busy_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        check("pulse_end", {31'd0, out_valid}, 32'd0);
        check("ready_again", {31'd0, in_ready}, 32'd1);
        check("hold_quotient", quotient, exp[31:0]);
    endtask

    initial begin
        logic [34:0] qexp[$];
        logic [31:0] ra, rb;
        logic [34:0] got;
        int seen, last_acc, n_res;

        // reset state
        #12;
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_quotient", quotient, 32'd0);
        check("rst_flags", {29'd0, div_by_zero, overflow, underflow}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // directed vectors
        do_op(32'h40C00000, 32'h40000000, {3'b000, 32'h40400000});
`ifdef FLOAT_DIV_ROUND_EN
        do_op(32'h3F800000, 32'h40400000, {3'b000, 32'h3EAAAAAB});
`else
        do_op(32'h3F800000, 32'h40400000, {3'b000, 32'h3EAAAAAA});
`endif
        do_op(32'hC0C00000, 32'h40000000, {3'b000, 32'hC0400000});
        do_op(32'h3F800000, 32'h00000000, {3'b100, 32'h7F800000});
        do_op(32'h7F000000, 32'h3E800000, {3'b010, 32'h7F800000});
        do_op(32'h00800000, 32'h40000000, {3'b001, 32'h00000000});
        do_op(32'h00000000, 32'h40000000, {3'b000, 32'h00000000});
        do_op(32'h00000000, 32'h00000000, {3'b100, 32'h7F800000});

        // randomized vectors vs. model
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 8 == 3) rb = 32'd0;
            if (i % 8 == 5) ra = 32'd0;
            do_op(ra, rb, ref_div(ra, rb));
        end

        // reset in the middle of DIVIDE
        do_op(32'h40C00000, 32'h40000000, {3'b000, 32'h40400000});
        @(negedge clk);
        in_valid = 1'b1;
        input_a  = 32'h3F800000;
        input_b  = 32'h40400000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_quotient", quotient, 32'd0);
        check("midrst_flags", {29'd0, div_by_zero, overflow, underflow}, 32'd0);
        check("midrst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 35; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_result", seen, 0);
        do_op(32'hC0C00000, 32'h40000000, {3'b000, 32'hC0400000});

        // in_valid held high with changing operands
        last_acc = -1;
        n_res    = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (out_valid) begin
                got = qexp.pop_front();
                check("stream_quotient", quotient, got[31:0]);
                check("stream_flags", {29'd0, div_by_zero, overflow, underflow}, {29'd0, got[34:32]});
                n_res++;
            end
            ra = $urandom;
            rb = $urandom;
            input_a  = ra;
            input_b  = rb;
            in_valid = 1'b1;
            if (in_ready) begin
                qexp.push_back(ref_div(ra, rb));
                if (last_acc >= 0) check("stream_spacing", cyc - last_acc, 29);
                last_acc = cyc;
            end
        end
        in_valid = 1'b0;
        check("stream_results", n_res, 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
